exp3_unidade_controle: RTL

//   Control unit (Moore FSM) for exp3_fluxo_dados. Drives zeraC/contaC/zeraR/registraR and consumes

---
 rtl/exp3_unidade_controle_if.sv | 27 ++
 rtl/exp3_unidade_controle.sv | 99 +++++++++
 2 files changed

// File: rtl/exp3_unidade_controle_if.sv
// Handshake bundle between the exp3 control unit and its datapath/environment.
// master = control unit side, slave = datapath/stimulus side.
interface exp3_unidade_controle_if;
  logic       iniciar;
  logic       jogada;
  logic       fimC;
  logic       chavesIgualMemoria;
  logic       zeraC;
  logic       contaC;
  logic       zeraR;
  logic       registraR;
  logic       pronto;
  logic       acertou;
  logic       errou;
  logic       timeout;
  logic [3:0] db_estado;

  modport master (
    input  iniciar, jogada, fimC, chavesIgualMemoria,
    output zeraC, contaC, zeraR, registraR, pronto, acertou, errou, timeout, db_estado
  );

  modport slave (
    output iniciar, jogada, fimC, chavesIgualMemoria,
    input  zeraC, contaC, zeraR, registraR, pronto, acertou, errou, timeout, db_estado
  );
endinterface

// File: rtl/exp3_unidade_controle.sv
// Moore control unit for exp3_fluxo_dados: one jogada per ROM position, ending in
// acerto (16 matches), erro (first mismatch) or timeout (no jogada within TIMEOUT_CYCLES).
module exp3_unidade_controle #(
  parameter int TIMEOUT_CYCLES = 1000,
  parameter int TW             = 10
) (
  input  logic                         clock,
  input  logic                         reset,
  exp3_unidade_controle_if.master      bus
);

  typedef enum logic [3:0] {
    INICIAL     = 4'b0000,
    PREPARA     = 4'b0001,
    ESPERA      = 4'b0010,
    REGISTRA    = 4'b0100,
    COMPARA     = 4'b0101,
    PROXIMO     = 4'b0110,
    FIM_ACERTO  = 4'b1010,
    FIM_ERRO    = 4'b1110,
    FIM_TIMEOUT = 4'b1111
  } estado_t;

  localparam logic [TW-1:0] TIMER_LIMITE = TW'((TIMEOUT_CYCLES == 0) ? 0 : TIMEOUT_CYCLES - 1);
  localparam bit            TIMEOUT_ON   = (TIMEOUT_CYCLES != 0);

  estado_t       estado;
  estado_t       proxEstado;
  logic [TW-1:0] timer;
  logic          jogadaD;
  logic          jpulse;
  logic          expirou;

  assign jpulse  = bus.jogada & ~jogadaD;
  assign expirou = TIMEOUT_ON && (timer == TIMER_LIMITE);

  // NOTE: proxEstado gets a default before the case so no path leaves it unassigned (no latch).
  always_comb begin
    proxEstado = INICIAL;
    unique case (estado)
      INICIAL:  proxEstado = bus.iniciar ? PREPARA : INICIAL;
      PREPARA:  proxEstado = ESPERA;
      ESPERA: begin
        if (jpulse)       proxEstado = REGISTRA;
        else if (expirou) proxEstado = FIM_TIMEOUT;
        else              proxEstado = ESPERA;
      end
      REGISTRA: proxEstado = COMPARA;
      COMPARA: begin
        if (!bus.chavesIgualMemoria) proxEstado = FIM_ERRO;
        else if (bus.fimC)           proxEstado = FIM_ACERTO;
        else                         proxEstado = PROXIMO;
      end
      PROXIMO:  proxEstado = ESPERA;
      FIM_ACERTO, FIM_ERRO, FIM_TIMEOUT:
        proxEstado = bus.iniciar ? PREPARA : estado;
      default:  proxEstado = INICIAL;
    endcase
  end

  // Outputs are registered from proxEstado, so each one is a pure function of the
  // state register one cycle later and never glitches with the inputs.
  // NOTE: all state here is updated with non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      estado        <= INICIAL;
      timer         <= '0;
      jogadaD       <= 1'b0;
      bus.zeraC     <= 1'b0;
      bus.contaC    <= 1'b0;
      bus.zeraR     <= 1'b0;
      bus.registraR <= 1'b0;
      bus.pronto    <= 1'b0;
      bus.acertou   <= 1'b0;
      bus.errou     <= 1'b0;
      bus.timeout   <= 1'b0;
    end else begin
      estado  <= proxEstado;
      jogadaD <= bus.jogada;

      if (estado != ESPERA)  timer <= '0;
      else if (timer != '1)  timer <= timer + 1'b1;

      bus.zeraC     <= (proxEstado == PREPARA);
      bus.zeraR     <= (proxEstado == PREPARA);
      bus.registraR <= (proxEstado == REGISTRA);
      bus.contaC    <= (proxEstado == PROXIMO);
      bus.pronto    <= (proxEstado == FIM_ACERTO) || (proxEstado == FIM_ERRO) ||
                       (proxEstado == FIM_TIMEOUT);
      bus.acertou   <= (proxEstado == FIM_ACERTO);
      bus.errou     <= (proxEstado == FIM_ERRO) || (proxEstado == FIM_TIMEOUT);
      bus.timeout   <= (proxEstado == FIM_TIMEOUT);
    end
  end

  assign bus.db_estado = estado;

endmodule
